// File: rtl/ecc_pkg.sv
// Shared secp256k1 constants and the point validator state type.
package ecc_pkg;

  localparam int WIDTH_DEFAULT = 256;

  localparam logic [255:0] P_SECP256K1  =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] B_SECP256K1  = 256'd7;
  localparam logic [255:0] GX_SECP256K1 =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY_SECP256K1 =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RANGE,
    ST_MUL_YY,
    ST_MUL_XX,
    ST_MUL_XXX,
    ST_COMPARE,
    ST_DONE
  } pv_state_t;

endpackage

// File: rtl/mod_mult_serial.sv
// Bit-serial MSB-first interleaved modular multiplier: result = a*b mod p.
// One load cycle then WIDTH iterations; done pulses for one cycle afterwards.
module mod_mult_serial #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             running;

  logic [WIDTH+1:0] p_ext;
  logic [WIDTH+1:0] dbl;
  logic [WIDTH+1:0] dbl_red;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] acc_next;

  // Operands stay below p, so each step needs only one conditional subtract
  // after doubling and one after adding a; WIDTH+2 bits hold every intermediate.
  always_comb begin
    p_ext    = {2'b00, p};
    dbl      = {1'b0, acc, 1'b0};
    dbl_red  = (dbl >= p_ext) ? dbl - p_ext : dbl;
    sum      = b_q[WIDTH-1] ? dbl_red + {2'b00, a_q} : dbl_red;
    acc_next = WIDTH'((sum >= p_ext) ? sum - p_ext : sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= '0;
        a_q     <= a;
        b_q     <= b;
        cnt     <= CW'(WIDTH);
        running <= 1'b1;
      end else if (running) begin
        acc <= acc_next;
        b_q <= {b_q[WIDTH-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/point_validator.sv
// Checks that (inX,inY) is reduced mod P and lies on y^2 = x^3 + B (a = 0).
// Optional ErrCode output is enabled by defining PV_ERRCODE_EN.
module point_validator
  import ecc_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] P     = WIDTH'(P_SECP256K1),
  parameter logic [WIDTH-1:0] B     = WIDTH'(B_SECP256K1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] inX,
  input  logic [WIDTH-1:0] inY,
  output logic             Busy,
  output logic             Done,
  output logic             Valid
`ifdef PV_ERRCODE_EN
  ,
  output logic [1:0]       ErrCode
`endif
);

  pv_state_t state, state_next;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y2_q;

  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_result;
  logic             mul_done;

  logic             x_big;
  logic             y_big;
  logic [WIDTH:0]   rhs_sum;
  logic [WIDTH-1:0] rhs;
  logic             on_curve;

  assign x_big    = (x_q >= P);
  assign y_big    = (y_q >= P);
  assign rhs_sum  = {1'b0, mul_result} + {1'b0, B};
  assign rhs      = WIDTH'((rhs_sum >= {1'b0, P}) ? rhs_sum - {1'b0, P} : rhs_sum);
  assign on_curve = (y2_q == rhs);

  mod_mult_serial #(.WIDTH(WIDTH)) u_mult (
    .clk    (Clk),
    .rst    (Reset),
    .start  (mul_start),
    .a      (mul_a),
    .b      (mul_b),
    .p      (P),
    .result (mul_result),
    .done   (mul_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Each product is launched on the edge that leaves the previous step, so
  // the operand mux reflects the multiply that is about to be loaded.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    mul_a      = y_q;
    mul_b      = y_q;
    case (state)
      ST_IDLE: begin
        if (Start) state_next = ST_RANGE;
      end
      ST_RANGE: begin
        if (x_big || y_big) begin
          state_next = ST_DONE;
        end else begin
          mul_start  = 1'b1;
          state_next = ST_MUL_YY;
        end
      end
      ST_MUL_YY: begin
        mul_a = x_q;
        mul_b = x_q;
        if (mul_done) begin
          mul_start  = 1'b1;
          state_next = ST_MUL_XX;
        end
      end
      ST_MUL_XX: begin
        mul_a = mul_result;
        mul_b = x_q;
        if (mul_done) begin
          mul_start  = 1'b1;
          state_next = ST_MUL_XXX;
        end
      end
      ST_MUL_XXX: begin
        if (mul_done) state_next = ST_COMPARE;
      end
      ST_COMPARE: state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign Busy = (state != ST_IDLE) && (state != ST_DONE);
  assign Done = (state == ST_DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q   <= '0;
      y_q   <= '0;
      y2_q  <= '0;
      Valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            x_q   <= inX;
            y_q   <= inY;
            Valid <= 1'b0;
          end
        end
        ST_MUL_YY: begin
          if (mul_done) y2_q <= mul_result;
        end
        ST_COMPARE: Valid <= on_curve;
        default: ;
      endcase
    end
  end

`ifdef PV_ERRCODE_EN
  // x out of range takes priority over y out of range.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ErrCode <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) ErrCode <= 2'd0;
        end
        ST_RANGE: begin
          if (x_big)      ErrCode <= 2'd1;
          else if (y_big) ErrCode <= 2'd2;
        end
        ST_COMPARE: ErrCode <= on_curve ? 2'd0 : 2'd3;
        default: ;
      endcase
    end
  end
`endif

endmodule
